// File: rtl/instr_loader_if.sv
// instr_loader_if: start/stream/memory-write/status bundle for instr_loader.
// slave = loader side, master = host side that drives start and the stream.
interface instr_loader_if #(
   parameter int ADDR_W = 10
);

   // Load request and byte stream
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;

   // Instruction memory byte write port
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;

   // Status
   logic              busy;
   logic              done;
   logic              err;

   modport slave (
      input  start,
      input  in_valid,
      input  in_data,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_data,
      output busy,
      output done,
      output err
   );

   modport master (
      output start,
      output in_valid,
      output in_data,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_data,
      input  busy,
      input  done,
      input  err
   );

endinterface

// File: rtl/instr_loader.sv
// instr_loader: receives a 16-bit word count plus 4*N little-endian bytes and writes
// them to instruction memory at byte addresses 0..4N-1, one write per accepted byte.
// Ports: clk, rstn (async, active-low), bus (instr_loader_if.slave):
//   start, in_valid/in_data/in_ready stream, mem_we/mem_addr/mem_data write port,
//   busy/done/err status.
// Optional macro LOADER_CHECKSUM_EN: a trailing XOR checksum byte is required.
module instr_loader #(
   parameter int ADDR_W = 10
) (
   input  logic          clk,
   input  logic          rstn,
   instr_loader_if.slave bus
);

   // Largest word count that still fits the memory without wrapping.
   localparam int unsigned MAX_WORDS = 2 ** (ADDR_W - 2);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_DONE,
      S_ERR
   } state_t;
`endif

   state_t            state_q;
   state_t            state_d;

   logic [7:0]        len_lo_q;
   logic [ADDR_W-1:0] last_q;
   logic [ADDR_W:0]   cnt_q;

   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        data_q;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic              ready;
   logic              accept;
   logic              start_ok;
   logic              last_byte;
   logic [15:0]       n_words;
   logic              n_too_big;
   logic              n_zero;

   // Word count is only meaningful while the high byte is on in_data.
   assign n_words   = {bus.in_data, len_lo_q};
   assign n_too_big = 32'(n_words) > MAX_WORDS;
   assign n_zero    = n_words == 16'd0;

   assign accept    = bus.in_valid && ready;
   assign last_byte = cnt_q == {1'b0, last_q};

   always_comb begin
      ready    = 1'b0;
      start_ok = 1'b0;
      unique case (state_q)
         S_IDLE,
         S_DONE,
         S_ERR: begin
            start_ok = bus.start;
         end
         S_LEN_LO,
         S_LEN_HI,
`ifdef LOADER_CHECKSUM_EN
         S_CSUM,
`endif
         S_DATA: begin
            ready = 1'b1;
         end
         default: begin
            ready    = 1'b0;
            start_ok = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE,
         S_DONE,
         S_ERR: begin
            if (start_ok) begin
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               state_d = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               if (n_too_big) begin
                  state_d = S_ERR;
               end else if (n_zero) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               if (bus.in_data == csum_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Length capture and the write pipeline; the write lands one cycle after accept.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         len_lo_q <= '0;
         last_q   <= '0;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         we_q <= 1'b0;
         if (start_ok) begin
            cnt_q <= '0;
         end
         if (state_q == S_LEN_LO && accept) begin
            len_lo_q <= bus.in_data;
         end
         if (state_q == S_LEN_HI && accept) begin
            // Index of the final byte, 4N-1; unused when N is zero.
            last_q <= ADDR_W'({n_words, 2'b00} - 18'd1);
         end
         if (state_q == S_DATA && accept) begin
            we_q   <= 1'b1;
            addr_q <= cnt_q[ADDR_W-1:0];
            data_q <= bus.in_data;
            cnt_q  <= cnt_q + (ADDR_W+1)'(1);
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         csum_q <= '0;
      end else begin
         if (start_ok) begin
            csum_q <= '0;
         end else if (state_q == S_DATA && accept) begin
            csum_q <= csum_q ^ bus.in_data;
         end
      end
   end
`endif

   assign bus.in_ready = ready;
   assign bus.mem_we   = we_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_data = data_q;
   // Stays busy through the trailing write after the last byte.
   assign bus.busy     = ready || we_q;
   assign bus.done     = state_q == S_DONE;
   assign bus.err      = state_q == S_ERR;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of the instruction memory; capacity 2^ADDR_W bytes.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 in_valid  input  1  byte stream source has a byte on in_data.
REQ-006 in_data  input  8  stream byte.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
REQ-008 mem_we  output  1  byte write strobe to instruction memory.
REQ-009 mem_addr  output  ADDR_W  byte address of the write.
REQ-010 mem_data  output  8  byte written.
REQ-011 busy  output  1  load in progress; CPU held from fetching while high.
REQ-012 done  output  1  load completed successfully.
REQ-013 err  output  1  load aborted.

Function
REQ-014 States: IDLE, LEN_LO, LEN_HI, DATA, CSUM (only with CHECKSUM_EN), DONE, ERR.
REQ-015 IDLE/DONE/ERR: start -> LEN_LO; clears done, err, byte counter and checksum; start in any other state is ignored.
REQ-016 in_ready = 1 exactly in LEN_LO, LEN_HI, DATA, CSUM; 0 elsewhere, including the cycle start is sampled.
REQ-017 LEN_LO accepts word count bits [7:0]; LEN_HI accepts bits [15:8]; word count N is 16-bit unsigned.
REQ-018 After LEN_HI: N > 2^ADDR_W/4 -> ERR; N == 0 -> DONE (or CSUM with CHECKSUM_EN); else -> DATA.
REQ-019 DATA: each accepted byte k (k = 0..4N-1) produces, on the following cycle only, mem_we=1, mem_addr=k, mem_data=byte; fixed 1-cycle latency, one write per accepted byte.
REQ-020 Byte order is little-endian: byte 4w+i is byte lane i of word w, so a fetch of {addr+3..addr} returns the transmitted word.
REQ-021 Byte counter is ADDR_W+1 bits wide; the length check of REQ-018 guarantees no address wrap.
REQ-022 Accepting byte 4N-1 -> DONE (or CSUM with CHECKSUM_EN) on the next edge; the last mem_we pulse coincides with the first DONE/CSUM cycle.
REQ-023 in_valid low in any accepting state stalls without timeout; no mem_we is generated.
REQ-024 busy = 1 in LEN_LO, LEN_HI, DATA, CSUM and during the trailing mem_we cycle; 0 otherwise.
REQ-025 done = 1 while in DONE; err = 1 while in ERR; both held until next start or reset.
REQ-026 mem_we is never asserted outside the cycle after an accepted DATA byte.

Reset
REQ-027 rstn low: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, err=0, counters and checksum 0, immediately and independent of clk.
REQ-028 Reset mid-load abandons the load with no further writes; already written memory bytes are not this block's concern.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: running XOR of all DATA bytes kept; CSUM state accepts one byte; equal -> DONE, unequal -> ERR.
REQ-030 LOADER_CHECKSUM_EN undefined: no CSUM state, no checksum register, no trailing byte consumed; last data byte -> DONE.

Verification
REQ-031 start, stream 01 00 13 05 A0 00 (N=1) -> writes addr0..3 = 13,05,A0,00 one cycle after each accept; done=1, busy=0, err=0.
REQ-032 start, stream 00 00 -> no mem_we, DONE (without macro) / CSUM awaiting byte 00 then DONE (with macro).
REQ-033 start, stream 01 01 (N=257) -> ERR, err=1, in_ready=0, no mem_we; subsequent start returns to LEN_LO with err=0.
REQ-034 N=256 with in_valid toggling every other cycle -> exactly 1024 writes, addresses 0..1023 in order, last address 1023.
REQ-035 rstn low after 5 data bytes -> all outputs 0 asynchronously; after release in_ready=0 until start.
REQ-036 LOADER_CHECKSUM_EN, N=1 data 11 22 33 44, checksum 44 -> DONE; checksum 45 -> ERR.
